mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported, byte-addressable unified memory of the pipelined RV32 core. It accepts instruction-fetch reads from the IF stage and load/store accesses from the MEM stage, and serialises them onto one memory port. It holds each command for a fixed memory latency and returns read data with a one-cycle valid pulse. The core's hazard unit uses `if_gnt`/`d_gnt`/`busy` to stall the pipeline.

## Interface
- `MEM_LAT`, 1: cycles a command is held on the memory port before read data is captured; legal 1..7.
- `STARVE_MAX`, 4: consecutive lost arbitrations after which fetch is forced to win; legal 1..7. Used only with `ARB_ANTISTARVE_EN`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  one-cycle pulse: fetch command accepted.
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid.
- `if_rdata`  out  32  fetched word.
- `d_req`  in  1  data request; held with its payload until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_func3`  in  3  RV32I width/sign code (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000/001/010).
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  one-cycle pulse: data command accepted.
- `d_rvalid`  out  1  one-cycle pulse: load data valid, or store completed.
- `d_rdata`  out  32  load data; 0 on store completion.
- `mem_re`, `mem_we`  out  1 each  memory read/write strobes.
- `mem_func3`  out  3  width code to memory.
- `mem_addr`  out  32  memory byte address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, already width/sign formatted by the memory.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: no command on the port.
  - BUSY_I: fetch command in flight.
  - BUSY_D: data command in flight.
- Reset (asynchronous, any time):
  - State goes to IDLE; latency counter, starvation counter and all registered outputs go to 0.
  - Any in-flight command is discarded; no `rvalid` is produced for it.
- IDLE, at a rising edge:
  - If any request is present, the winner's command is latched into the `mem_*` registers.
  - The winner's `gnt` pulses in the next cycle, and the FSM enters BUSY_I or BUSY_D with counter = 0.
- Arbitration:
  - Data beats fetch (the MEM stage holds the older instruction).
  - Only one requester present: that requester wins.
  - Neither present: stay in IDLE.
- Fetch commands are issued with `mem_re`=1, `mem_func3`=010, `mem_wdata`=0.
- Data commands are issued with `mem_re`=~`d_we`, `mem_we`=`d_we`, and `d_func3`/`d_addr`/`d_wdata` passed unchanged. Illegal `d_func3` values are forwarded as-is; the memory returns 0 for them.
- BUSY_x:
  - `mem_addr`, `mem_func3`, `mem_wdata` and `mem_re` are held stable.
  - `mem_we` is high only in the first BUSY cycle, so exactly one write edge occurs per store.
  - The counter increments each cycle. At the edge where counter = MEM_LAT−1:
    - `mem_rdata` is captured into the winner's `rdata`; for a store, `d_rdata` = 0.
    - The winner's `rvalid` pulses in the next cycle.
    - `mem_re` clears and the FSM returns to IDLE.
- Requests present during BUSY are not sampled; they wait for IDLE.
- `if_rdata`/`d_rdata` hold their last value until the next capture.

## Timing
- Request sampled at edge E0 (state IDLE):
  - `gnt` and the `mem_*` command are valid in cycle E0..E1.
  - `rvalid` and `rdata` are valid in cycle E(MEM_LAT)..E(MEM_LAT+1).
- Back-to-back throughput: one command per MEM_LAT+1 cycles. The cycle in which `rvalid` is high is an IDLE cycle, and a new request is sampled at its closing edge.
- `gnt` and `rvalid` are always exactly one cycle wide and never high together for the same requester.
- `busy` is asserted from the `gnt` cycle through the last BUSY cycle.

## Configuration
- Macro: `ARB_ANTISTARVE_EN`.
- Defined:
  - A 3-bit starvation counter increments at each IDLE arbitration where `if_req`=1 but data wins.
  - When the counter reaches STARVE_MAX, the next arbitration with `if_req`=1 grants fetch even if `d_req`=1.
  - The counter clears whenever fetch is granted, and on reset.
- Undefined:
  - Strict data priority; fetch can starve indefinitely.
  - No counter logic is generated.

## Test plan
- Reset mid-transaction: issue a lw at 0x10 with MEM_LAT=3, pull `rst` low in BUSY cycle 2 → all outputs 0 immediately, no `d_rvalid`; after release, first request is granted normally.
- Single fetch, MEM_LAT=1: `if_req` @0x0, memory returns 0x00500093 → `if_gnt` in cycle 1, `mem_func3`=010, `if_rvalid`=1 with `if_rdata`=0x00500093 in cycle 2.
- Simultaneous requests: `if_req` @0x4 and `d_req` lw @0x100 in the same cycle → data granted first, fetch granted in the IDLE cycle after `d_rvalid`, order D,I.
- Store: sw 0xDEADBEEF @0x20, MEM_LAT=4 → `mem_we` high exactly one cycle, `mem_addr` held 4 cycles, `d_rvalid` with `d_rdata`=0.
- Anti-starvation (macro defined, STARVE_MAX=2): `d_req` held continuously with `if_req` high → grant sequence D,D,I,D,D,I. With the macro undefined → D only.
- Byte load: lb @0x33, memory returns 0xFFFFFF80 → `mem_func3`=000, `d_rdata`=0xFFFFFF80, throughput one grant per MEM_LAT+1 cycles over 8 back-to-back loads.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter and fixed-latency sequencer for a single-ported unified memory.
// Optional fetch anti-starvation counter is built only when ARB_ANTISTARVE_EN is defined.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] FUNC3_LW = 3'b010;
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be in 1..7");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       fetch_wins;

`ifdef ARB_ANTISTARVE_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt;

  // Once fetch has lost STARVE_MAX times in a row it overrides data priority.
  assign fetch_wins = if_req && (!d_req || (starve_cnt >= STARVE_LIM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE && if_req) begin
      if (fetch_wins) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`else
  assign fetch_wins = if_req && !d_req;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_func3 <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          if (fetch_wins) begin
            state     <= BUSY_I;
            if_gnt    <= 1'b1;
            mem_re    <= 1'b1;
            mem_we    <= 1'b0;
            mem_func3 <= FUNC3_LW;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (d_req) begin
            state     <= BUSY_D;
            d_gnt     <= 1'b1;
            mem_re    <= ~d_we;
            mem_we    <= d_we;
            mem_func3 <= d_func3;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end
        end
        BUSY_I, BUSY_D: begin
          // A single write strobe per store, whatever the latency.
          mem_we <= 1'b0;
          if (lat_cnt == LAT_LAST) begin
            state   <= IDLE;
            lat_cnt <= '0;
            mem_re  <= 1'b0;
            if (state == BUSY_I) begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end else begin
              // mem_re is low for the whole of a store, so it marks store completion.
              d_rdata  <= mem_re ? mem_rdata : 32'h0;
              d_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) !(if_gnt && d_gnt));
  a_if_gnt_rvalid: assert property (@(posedge clk) disable iff (!rst) !(if_gnt && if_rvalid));
  a_d_gnt_rvalid: assert property (@(posedge clk) disable iff (!rst) !(d_gnt && d_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 1, 3, 4; STARVE_MAX 2)
// driven by a cycle table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int N = 3;
  localparam logic [31:0] Z = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]       if_req, d_req, d_we;
  logic [N-1:0][31:0] if_addr, d_addr, d_wdata;
  logic [N-1:0][2:0]  d_func3;
  wire  [N-1:0]       if_gnt, if_rvalid, d_gnt, d_rvalid, mem_re, mem_we, busy;
  wire  [N-1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  wire  [N-1:0][2:0]  mem_func3;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00000013;
      32'h10:  return 32'h11223344;
      32'h100: return 32'hCAFEF00D;
      32'h33:  return 32'hFFFFFF80;
      default: return a ^ 32'hA5A50000;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    assign mem_rdata[g] = mem_model(mem_addr[g]);
    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(2)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_func3(d_func3[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_re(mem_re[g]), .mem_we(mem_we[g]), .mem_func3(mem_func3[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g])
    );
  end

  typedef struct packed {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [2:0]  df;
    logic [31:0] da;
    logic [31:0] dwd;
  } in_t;

  typedef struct packed {
    logic        ig;
    logic        irv;
    logic [31:0] ird;
    logic        dg;
    logic        drv;
    logic [31:0] drd;
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bsy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  function automatic in_t iv(input logic ir, input logic [31:0] ia, input logic dr,
                             input logic dw, input logic [2:0] df, input logic [31:0] da,
                             input logic [31:0] dwd);
    return {ir, ia, dr, dw, df, da, dwd};
  endfunction

  function automatic out_t ov(input logic ig, input logic irv, input logic [31:0] ird,
                              input logic dg, input logic drv, input logic [31:0] drd,
                              input logic re, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic bsy);
    return {ig, irv, ird, dg, drv, drd, re, we, f3, addr, wdata, bsy};
  endfunction

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input int k, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    d_req[k] = 1'b1; d_we[k] = we; d_func3[k] = f3; d_addr[k] = a; d_wdata[k] = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[15];
  out_t act;
  int   n, m, weh, held, ngnt, nrv, last_gnt, bad_gap, bad_f3, bad_data;
  logic seen;
  logic [5:0] seq, seq_exp;

  initial begin
    if_req = '0; if_addr = '0; d_req = '0; d_we = '0; d_func3 = '0; d_addr = '0; d_wdata = '0;

    vecs[0]  = {iv(1'b0, Z, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, 3'd0, Z, Z, 1'b0)};
    vecs[1]  = {iv(1'b1, Z, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, 3'd0, Z, Z, 1'b0)};
    vecs[2]  = {iv(1'b1, Z, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b1, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1, 1'b0, 3'd2, Z, Z, 1'b1)};
    vecs[3]  = {iv(1'b0, Z, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, Z, 1'b0, 1'b0, 3'd2, Z, Z, 1'b0)};
    vecs[4]  = {iv(1'b1, 32'h4, 1'b1, 1'b0, 3'd2, 32'h100, Z),
                ov(1'b0, 1'b0, 32'h00500093, 1'b0, 1'b0, Z, 1'b0, 1'b0, 3'd2, Z, Z, 1'b0)};
    vecs[5]  = {iv(1'b1, 32'h4, 1'b1, 1'b0, 3'd2, 32'h100, Z),
                ov(1'b0, 1'b0, 32'h00500093, 1'b1, 1'b0, Z, 1'b1, 1'b0, 3'd2, 32'h100, Z, 1'b1)};
    vecs[6]  = {iv(1'b1, 32'h4, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b0, 1'b0, 32'h00500093, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 3'd2, 32'h100, Z, 1'b0)};
    vecs[7]  = {iv(1'b1, 32'h4, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b1, 1'b0, 32'h00500093, 1'b0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 3'd2, 32'h4, Z, 1'b1)};
    vecs[8]  = {iv(1'b0, Z, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 3'd2, 32'h4, Z, 1'b0)};
    vecs[9]  = {iv(1'b0, Z, 1'b1, 1'b1, 3'd0, 32'h21, 32'hAB),
                ov(1'b0, 1'b0, 32'h13, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 3'd2, 32'h4, Z, 1'b0)};
    vecs[10] = {iv(1'b0, Z, 1'b1, 1'b1, 3'd0, 32'h21, 32'hAB),
                ov(1'b0, 1'b0, 32'h13, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 3'd0, 32'h21, 32'hAB, 1'b1)};
    vecs[11] = {iv(1'b0, Z, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b0, 1'b0, 32'h13, 1'b0, 1'b1, Z, 1'b0, 1'b0, 3'd0, 32'h21, 32'hAB, 1'b0)};
    vecs[12] = {iv(1'b1, 32'h8, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b0, 1'b0, 32'h13, 1'b0, 1'b0, Z, 1'b0, 1'b0, 3'd0, 32'h21, 32'hAB, 1'b0)};
    vecs[13] = {iv(1'b1, 32'h8, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b1, 1'b0, 32'h13, 1'b0, 1'b0, Z, 1'b1, 1'b0, 3'd2, 32'h8, Z, 1'b1)};
    vecs[14] = {iv(1'b0, Z, 1'b0, 1'b0, 3'd0, Z, Z),
                ov(1'b0, 1'b1, 32'hA5A50008, 1'b0, 1'b0, Z, 1'b0, 1'b0, 3'd2, 32'h8, Z, 1'b0)};

    tick(); tick();
    rst = 1'b1;
    chk("reset_k1", 160'({busy[1], mem_re[1], mem_we[1], mem_addr[1], d_rdata[1], if_rdata[1]}), 160'(0));
    chk("reset_k2", 160'({busy[2], if_gnt[2], d_gnt[2], mem_func3[2], mem_wdata[2]}), 160'(0));

    for (int r = 0; r < 15; r++) begin
      if_req[0] = vecs[r].i.ir;  if_addr[0] = vecs[r].i.ia;
      d_req[0]  = vecs[r].i.dr;  d_we[0]    = vecs[r].i.dw;  d_func3[0] = vecs[r].i.df;
      d_addr[0] = vecs[r].i.da;  d_wdata[0] = vecs[r].i.dwd;
      @(negedge clk);
      act = {if_gnt[0], if_rvalid[0], if_rdata[0], d_gnt[0], d_rvalid[0], d_rdata[0],
             mem_re[0], mem_we[0], mem_func3[0], mem_addr[0], mem_wdata[0], busy[0]};
      chk($sformatf("vec%0d", r), 160'(act), 160'(vecs[r].o));
      tick();
    end

    // Reset in the middle of a MEM_LAT=3 load.
    drive_d(1, 1'b0, 3'b010, 32'h10, Z);
    tick();
    chk("rst_gnt", 160'(d_gnt[1]), 160'(1));
    d_req[1] = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_async_clear", 160'({busy[1], mem_re[1], mem_we[1], mem_func3[1], mem_addr[1],
                                 d_gnt[1], d_rvalid[1]}), 160'(0));
    chk("rst_clr_if_rdata0", 160'(if_rdata[0]), 160'(0));
    tick(); tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (d_rvalid[1]) seen = 1'b1;
    end
    chk("rst_no_rvalid", 160'(seen), 160'(0));
    drive_d(1, 1'b0, 3'b010, 32'h10, Z);
    n = 0;
    do begin tick(); n++; end while (!d_gnt[1] && n < 6);
    chk("post_rst_gnt_lat", 160'(n), 160'(1));
    d_req[1] = 1'b0;
    m = 0;
    do begin tick(); m++; end while (!d_rvalid[1] && m < 10);
    chk("post_rst_rvalid_lat", 160'(m), 160'(3));
    chk("post_rst_rdata", 160'(d_rdata[1]), 160'(32'h11223344));

    // Store with MEM_LAT=4.
    drive_d(2, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    tick();
    chk("sw_cmd", 160'({d_gnt[2], mem_re[2], mem_we[2], mem_func3[2], mem_addr[2], mem_wdata[2]}),
        160'({1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF}));
    d_req[2] = 1'b0;
    weh  = mem_we[2] ? 1 : 0;
    held = (busy[2] && mem_addr[2] == 32'h20) ? 1 : 0;
    m = 0;
    do begin
      tick(); m++;
      if (mem_we[2]) weh++;
      if (busy[2] && mem_addr[2] == 32'h20) held++;
    end while (!d_rvalid[2] && m < 12);
    chk("sw_we_cycles", 160'(weh), 160'(1));
    chk("sw_addr_held", 160'(held), 160'(4));
    chk("sw_rvalid_lat", 160'(m), 160'(4));
    chk("sw_rdata_zero", 160'(d_rdata[2]), 160'(0));

    // Eight back-to-back byte loads with MEM_LAT=3.
    drive_d(1, 1'b0, 3'b000, 32'h33, Z);
    ngnt = 0; nrv = 0; last_gnt = 0; bad_gap = 0; bad_f3 = 0; bad_data = 0;
    for (int c = 0; c < 60 && nrv < 8; c++) begin
      tick();
      if (d_gnt[1]) begin
        if (ngnt > 0 && (cyc - last_gnt) != 4) bad_gap++;
        if (mem_func3[1] != 3'b000) bad_f3++;
        last_gnt = cyc;
        ngnt++;
        if (ngnt == 8) d_req[1] = 1'b0;
      end
      if (d_rvalid[1]) begin
        nrv++;
        if (d_rdata[1] != 32'hFFFFFF80) bad_data++;
      end
    end
    d_req[1] = 1'b0;
    chk("lb_gnt_count", 160'(ngnt), 160'(8));
    chk("lb_gap", 160'(bad_gap), 160'(0));
    chk("lb_func3", 160'(bad_f3), 160'(0));
    chk("lb_rdata", 160'({nrv, bad_data}), 160'({32'd8, 32'd0}));

    // Fetch and data both held continuously, MEM_LAT=1, STARVE_MAX=2.
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    drive_d(0, 1'b0, 3'b010, 32'h44, Z);
    n = 0; seq = '0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (d_gnt[0]) n++;
      if (if_gnt[0]) begin seq[n] = 1'b1; n++; end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
`ifdef ARB_ANTISTARVE_EN
    seq_exp = 6'b100100;
`else
    seq_exp = 6'b000000;
`endif
    chk("starve_grants", 160'(n), 160'(6));
    chk("starve_order", 160'(seq), 160'(seq_exp));

    tick(); tick(); tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
